fft_agu: RTL and testbench
==========================

# fft_agu

Address-generation and sequencing controller for the in-place radix-2 FFT datapath. It steps through every stage and butterfly, and drives the read addresses for operands a and b and the twiddle-ROM address into the combinational butterfly. It also drives the delayed write-back addresses and write enable that store aout/bout back into the ping-pong sample RAMs (RAM0/RAM1). It sits between the sample-load logic, which fills RAM0, and the spectrum readout, which reads the result RAM once `done` pulses.

## Interface
- `N_LOG2`, 9, log2 of FFT length N (N = 512)
- `RD_LAT`, 1, cycles from read address to valid butterfly output (RAM read latency)
- `clk` input 1 — single system clock, rising edge
- `reset` input 1 — synchronous, active-high
- `start` input 1 — begin transform; sampled only in IDLE
- `stall` input 1 — freeze sequencing (only with `FFT_AGU_STALL_EN`)
- `adr_a` output N_LOG2 — read address of operand a
- `adr_b` output N_LOG2 — read address of operand b
- `tw_adr` output N_LOG2-1 — twiddle ROM address
- `rd_sel` output 1 — RAM read this stage (0 = RAM0, 1 = RAM1); write RAM is `~rd_sel`
- `wr_adr_a` output N_LOG2 — write-back address for aout
- `wr_adr_b` output N_LOG2 — write-back address for bout
- `we` output 1 — write-back enable
- `busy` output 1 — transform in progress
- `done` output 1 — one-cycle pulse when final write-back has completed
- `res_sel` output 1 — RAM holding final result: `N_LOG2[0]`, i.e. RAM0 if N_LOG2 is even

## Operation
- Counters:
  - stage `s`: 0..N_LOG2-1
  - butterfly `i`: 0..N/2-1 (N_LOG2-1 bits)
  - flush counter: 0..RD_LAT-1
- Address rules, in-place decimation-in-time with inputs pre-loaded in bit-reversed order:
  - `adr_a = rotl_N_LOG2({i,1'b0}, s)`
  - `adr_b = rotl_N_LOG2({i,1'b1}, s)`
  - `tw_adr = i & (all-ones << (N_LOG2-1-s))`, computed in N_LOG2-1 bits
- `rd_sel = s[0]`.
- Write-back path: `wr_adr_a`, `wr_adr_b` and `we` are the read-side address and valid delayed by exactly RD_LAT cycles through a shift pipeline. The write RAM select is the delayed `~rd_sel`.
- FSM states:
  - IDLE: `busy=0`. `start=1` → RUN with s=0, i=0.
  - RUN: issues one butterfly per cycle and increments i. At i=N/2-1 → FLUSH.
  - FLUSH: RD_LAT cycles with no new reads, so the pipeline drains before the next stage reads the RAM just written. Then, if s<N_LOG2-1: s++, i=0, → RUN. Otherwise → DONE.
  - DONE: `done=1` for one cycle → IDLE.
- `start` while busy is ignored. `start` held high in IDLE launches a new transform every time the FSM returns to IDLE.
- Reset in any state:
  - FSM goes to IDLE, counters and the delay pipeline clear.
  - `we` is 0 from the next edge, so no partial write-back occurs.
  - RAM contents are undefined.

## Timing
- Reset values: `adr_a`, `adr_b`, `tw_adr`, `wr_adr_a`, `wr_adr_b` = 0; `rd_sel` = 0; `we`, `busy`, `done` = 0.
- `busy` rises the cycle after `start` is sampled in IDLE. It falls in the same cycle `done` pulses.
- Read outputs are registered. A butterfly's read address appears in cycle t; its `we` and write address appear in cycle t+RD_LAT.
- Each stage takes N/2 RUN cycles plus RD_LAT FLUSH cycles. Total busy time is N_LOG2·(N/2+RD_LAT)+1 cycles, including DONE; N_LOG2=9, RD_LAT=1 gives 2314.
- The last `we` of each stage occurs in the final FLUSH cycle. No read of stage s+1 overlaps any write of stage s.

## Configuration
- `FFT_AGU_STALL_EN` defined:
  - `stall=1` holds all counters, the FSM and the read outputs, and zeroes `we` into the delay pipeline.
  - Already-issued write-backs still drain.
  - Stall in IDLE delays acceptance of `start`.
- Not defined: the `stall` port exists but is ignored; behaviour is identical to `stall=0`.

## Test plan
- N_LOG2=3, RD_LAT=1, `start` pulse:
  - stage 0: adr_a 0,2,4,6; adr_b 1,3,5,7; tw 0,0,0,0; rd_sel 0.
  - stage 1: adr_a 0,4,1,5; adr_b 2,6,3,7; tw 0,0,2,2; rd_sel 1.
  - stage 2: adr_a 0,1,2,3; adr_b 4,5,6,7; tw 0,1,2,3; rd_sel 0.
- Same configuration: `busy` high exactly 16 cycles, `done` a single pulse, `res_sel` = 1. Each `we` pulse matches the read addresses of the prior cycle; 12 `we` pulses total.
- N_LOG2=9 with a bench model of the ping-pong RAMs plus the butterfly, fed an impulse at x[0] → all 512 bins equal the impulse value (±1 LSB) in RAM1.
- `start` re-asserted mid-transform → no restart, cycle count unchanged. `reset` at cycle 7 → all outputs 0 next cycle; a new `start` produces the full stage-0 sequence.
- With `FFT_AGU_STALL_EN`: `stall` high 3 cycles at stage 1, i=2 → adr_a held at 1 and `we` low for 3 cycles after drain. Busy time extends by exactly 3 cycles, with an identical address sequence otherwise.

Source files
------------

// File: rtl/fft_agu_if.sv
// Read/write-back address bus between the FFT sequencer and the butterfly/RAM datapath.
interface fft_agu_if #(
  parameter int N_LOG2 = 9
);
  logic              start;
  logic              stall;
  logic [N_LOG2-1:0] adr_a;
  logic [N_LOG2-1:0] adr_b;
  logic [N_LOG2-2:0] tw_adr;
  logic              rd_sel;
  logic [N_LOG2-1:0] wr_adr_a;
  logic [N_LOG2-1:0] wr_adr_b;
  logic              we;
  logic              busy;
  logic              done;
  logic              res_sel;

  modport master (
    input  start, stall,
    output adr_a, adr_b, tw_adr, rd_sel, wr_adr_a, wr_adr_b, we, busy, done, res_sel
  );

  modport slave (
    output start, stall,
    input  adr_a, adr_b, tw_adr, rd_sel, wr_adr_a, wr_adr_b, we, busy, done, res_sel
  );
endinterface

// File: rtl/fft_agu.sv
// In-place radix-2 DIT FFT address generator: stage/butterfly sequencing, twiddle address, delayed write-back.
// Optional macro FFT_AGU_STALL_EN enables the stall input; otherwise stall is ignored.
module fft_agu #(
  parameter int N_LOG2 = 9,
  parameter int RD_LAT = 1
) (
  input logic       clk,
  input logic       reset,
  fft_agu_if.master bus
);
  localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam int FW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
  localparam logic [N_LOG2-2:0] I_LAST = '1;
  localparam logic [FW-1:0]     F_LAST = FW'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [N_LOG2-2:0] i_q, i_d;
  logic [FW-1:0]     f_q, f_d;
  logic [N_LOG2-1:0] adr_a_q, adr_a_d, adr_b_q, adr_b_d;
  logic [N_LOG2-2:0] tw_q, tw_d;
  logic              rd_sel_q, rd_sel_d;
  logic              issue;
  logic              we_pipe_q [RD_LAT];
  logic              we_pipe_d [RD_LAT];
  logic [N_LOG2-1:0] wa_pipe_q [RD_LAT];
  logic [N_LOG2-1:0] wa_pipe_d [RD_LAT];
  logic [N_LOG2-1:0] wb_pipe_q [RD_LAT];
  logic [N_LOG2-1:0] wb_pipe_d [RD_LAT];
  logic              stall_w;

`ifdef FFT_AGU_STALL_EN
  assign stall_w = bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign stall_w      = 1'b0;
`endif

  function automatic logic [N_LOG2-1:0] rotl(input logic [N_LOG2-1:0] x, input logic [SW-1:0] sh);
    logic [2*N_LOG2-1:0] dbl;
    dbl = {x, x} << sh;
    return dbl[2*N_LOG2-1:N_LOG2];
  endfunction

  // Twiddle index keeps only the top s bits of i: stage s uses 2^s distinct twiddles.
  function automatic logic [N_LOG2-2:0] tw_of(input logic [N_LOG2-2:0] i, input logic [SW-1:0] sh);
    logic [N_LOG2-2:0] mask;
    mask = I_LAST << (N_LOG2 - 1 - int'(sh));
    return i & mask;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    i_d     = i_q;
    f_d     = f_q;
    issue   = 1'b0;
    if (!stall_w) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_RUN;
            s_d     = '0;
            i_d     = '0;
          end
        end
        S_RUN: begin
          issue = 1'b1;
          if (i_q == I_LAST) begin
            state_d = S_FLUSH;
            f_d     = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (f_q == F_LAST) begin
            if (s_q == S_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              s_d     = s_q + 1'b1;
              i_d     = '0;
            end
          end else begin
            f_d = f_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          s_d     = '0;
          i_d     = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Read outputs are registered from next-state counters so they align with the RUN cycle.
    adr_a_d  = rotl({i_d, 1'b0}, s_d);
    adr_b_d  = rotl({i_d, 1'b1}, s_d);
    tw_d     = tw_of(i_d, s_d);
    rd_sel_d = s_d[0];

    we_pipe_d[0] = issue;
    wa_pipe_d[0] = adr_a_q;
    wb_pipe_d[0] = adr_b_q;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      we_pipe_d[k] = we_pipe_q[k-1];
      wa_pipe_d[k] = wa_pipe_q[k-1];
      wb_pipe_d[k] = wb_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      s_q      <= '0;
      i_q      <= '0;
      f_q      <= '0;
      adr_a_q  <= '0;
      adr_b_q  <= '0;
      tw_q     <= '0;
      rd_sel_q <= 1'b0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        we_pipe_q[k] <= 1'b0;
        wa_pipe_q[k] <= '0;
        wb_pipe_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      i_q      <= i_d;
      f_q      <= f_d;
      adr_a_q  <= adr_a_d;
      adr_b_q  <= adr_b_d;
      tw_q     <= tw_d;
      rd_sel_q <= rd_sel_d;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        we_pipe_q[k] <= we_pipe_d[k];
        wa_pipe_q[k] <= wa_pipe_d[k];
        wb_pipe_q[k] <= wb_pipe_d[k];
      end
    end
  end

  assign bus.adr_a    = adr_a_q;
  assign bus.adr_b    = adr_b_q;
  assign bus.tw_adr   = tw_q;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.wr_adr_a = wa_pipe_q[RD_LAT-1];
  assign bus.wr_adr_b = wb_pipe_q[RD_LAT-1];
  assign bus.we       = we_pipe_q[RD_LAT-1];
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.res_sel  = 1'(N_LOG2 % 2);
endmodule

// File: tb/tb_fft_agu.sv
// Directed bench for fft_agu: N=8 address tables, start/reset/stall behaviour, N=512 impulse transform.
module tb_fft_agu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fft_agu_if #(.N_LOG2(3)) b3 ();
  fft_agu_if #(.N_LOG2(9)) b9 ();

  fft_agu #(.N_LOG2(3), .RD_LAT(1)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.master));
  fft_agu #(.N_LOG2(9), .RD_LAT(1)) u_dut9 (.clk(clk), .reset(reset), .bus(b9.master));

  int exp_a [12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  int exp_t [12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 2, 3};

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    b3.start = 1'b0; b3.stall = 1'b0;
    b9.start = 1'b0; b9.stall = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_rd got a=%0d b=%0d tw=%0d sel=%0d want all 0", b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel);
    end
    n_cmp++;
    if ({b3.wr_adr_a, b3.wr_adr_b, b3.we} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_wr got wa=%0d wb=%0d we=%0d want all 0", b3.wr_adr_a, b3.wr_adr_b, b3.we);
    end
    n_cmp++;
    if ({b3.busy, b3.done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ctl got busy=%0d done=%0d want 0 0", b3.busy, b3.done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sequence;
    int busy_cnt, we_cnt, done_cnt, st, k, idx;
    busy_cnt = 0; we_cnt = 0; done_cnt = 0;
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      busy_cnt += int'(b3.busy);
      we_cnt   += int'(b3.we);
      done_cnt += int'(b3.done);
      st = c / 5;
      k  = c % 5;
      if (c == 15) begin
        n_cmp++;
        if ({b3.done, b3.we} !== 2'b10) begin
          n_bad++;
          $display("FAIL seq_done_cycle got done=%0d we=%0d want 1 0", b3.done, b3.we);
        end
      end else begin
        if (k < 4) begin
          idx = st * 4 + k;
          n_cmp++;
          if ({b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel} !==
              {3'(exp_a[idx]), 3'(exp_b[idx]), 2'(exp_t[idx]), 1'(st % 2)}) begin
            n_bad++;
            $display("FAIL seq_rd c=%0d got a=%0d b=%0d tw=%0d sel=%0d want a=%0d b=%0d tw=%0d sel=%0d",
                     c, b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel, exp_a[idx], exp_b[idx], exp_t[idx], st % 2);
          end
        end
        if (k == 0) begin
          n_cmp++;
          if (b3.we !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_we_idle c=%0d got we=%0d want 0", c, b3.we);
          end
        end else begin
          idx = st * 4 + k - 1;
          n_cmp++;
          if ({b3.we, b3.wr_adr_a, b3.wr_adr_b} !== {1'b1, 3'(exp_a[idx]), 3'(exp_b[idx])}) begin
            n_bad++;
            $display("FAIL seq_wr c=%0d got we=%0d wa=%0d wb=%0d want 1 %0d %0d",
                     c, b3.we, b3.wr_adr_a, b3.wr_adr_b, exp_a[idx], exp_b[idx]);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (b3.busy !== 1'b0 || b3.done !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_after got busy=%0d done=%0d want 0 0", b3.busy, b3.done);
    end
    n_cmp++;
    if (busy_cnt != 16) begin n_bad++; $display("FAIL seq_busy_cycles got %0d want 16", busy_cnt); end
    n_cmp++;
    if (we_cnt != 12) begin n_bad++; $display("FAIL seq_we_pulses got %0d want 12", we_cnt); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL seq_done_pulses got %0d want 1", done_cnt); end
    n_cmp++;
    if (b3.res_sel !== 1'b1) begin n_bad++; $display("FAIL res_sel got %0d want 1", b3.res_sel); end
  endtask

  task automatic test_start_ignored;
    int cnt, c;
    cnt = 0; c = 0;
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    while (b3.busy === 1'b1 && c < 100) begin
      cnt++;
      b3.start = (c == 5 || c == 6);
      c++;
      tick();
    end
    b3.start = 1'b0;
    n_cmp++;
    if (cnt != 16) begin n_bad++; $display("FAIL start_ignored_busy got %0d want 16", cnt); end
    tick();
    n_cmp++;
    if (b3.busy !== 1'b0) begin n_bad++; $display("FAIL start_ignored_restart got busy=%0d want 0", b3.busy); end
  endtask

  task automatic test_start_held;
    int run, gap;
    run = 0; gap = 0;
    b3.start = 1'b1; tick();
    while (b3.busy === 1'b1 && run < 100) begin run++; tick(); end
    while (b3.busy !== 1'b1 && gap < 10) begin gap++; tick(); end
    b3.start = 1'b0;
    n_cmp++;
    if (gap != 1) begin n_bad++; $display("FAIL start_held_gap got %0d want 1", gap); end
    run = 0;
    while (b3.busy === 1'b1 && run < 100) begin run++; tick(); end
    n_cmp++;
    if (run != 16) begin n_bad++; $display("FAIL start_held_second_run got %0d want 16", run); end
  endtask

  task automatic test_reset_mid;
    int c;
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    repeat (7) tick();
    reset = 1'b1; tick();
    n_cmp++;
    if ({b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel, b3.wr_adr_a, b3.wr_adr_b, b3.we, b3.busy, b3.done} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_mid got a=%0d b=%0d tw=%0d sel=%0d wa=%0d wb=%0d we=%0d busy=%0d done=%0d want all 0",
               b3.adr_a, b3.adr_b, b3.tw_adr, b3.rd_sel, b3.wr_adr_a, b3.wr_adr_b, b3.we, b3.busy, b3.done);
    end
    reset = 1'b0; tick();
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({b3.busy, b3.adr_a, b3.adr_b, b3.we} !== {1'b1, 3'(exp_a[k]), 3'(exp_b[k]), (k != 0)}) begin
        n_bad++;
        $display("FAIL reset_restart k=%0d got busy=%0d a=%0d b=%0d we=%0d want 1 %0d %0d %0d",
                 k, b3.busy, b3.adr_a, b3.adr_b, b3.we, exp_a[k], exp_b[k], int'(k != 0));
      end
      tick();
    end
    c = 0;
    while (b3.busy === 1'b1 && c < 100) begin c++; tick(); end
    n_cmp++;
    if (b3.busy !== 1'b0) begin n_bad++; $display("FAIL reset_restart_timeout got busy=%0d want 0", b3.busy); end
  endtask

`ifdef FFT_AGU_STALL_EN
  task automatic test_stall;
    int cnt, c;
    cnt = 0;
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    for (int j = 0; j < 7; j++) begin cnt += int'(b3.busy); tick(); end
    cnt += int'(b3.busy);
    n_cmp++;
    if ({b3.adr_a, b3.we} !== {3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL stall_pre got a=%0d we=%0d want 1 1", b3.adr_a, b3.we);
    end
    b3.stall = 1'b1; tick();
    for (int j = 0; j < 3; j++) begin
      cnt += int'(b3.busy);
      n_cmp++;
      if ({b3.adr_a, b3.we, b3.busy} !== {3'd1, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL stall_hold j=%0d got a=%0d we=%0d busy=%0d want 1 0 1", j, b3.adr_a, b3.we, b3.busy);
      end
      if (j == 2) b3.stall = 1'b0;
      tick();
    end
    n_cmp++;
    if ({b3.adr_a, b3.we, b3.wr_adr_a, b3.wr_adr_b} !== {3'd5, 1'b1, 3'd1, 3'd3}) begin
      n_bad++;
      $display("FAIL stall_resume got a=%0d we=%0d wa=%0d wb=%0d want 5 1 1 3", b3.adr_a, b3.we, b3.wr_adr_a, b3.wr_adr_b);
    end
    c = 0;
    while (b3.busy === 1'b1 && c < 100) begin cnt++; c++; tick(); end
    n_cmp++;
    if (cnt != 19) begin n_bad++; $display("FAIL stall_busy_cycles got %0d want 19", cnt); end
  endtask
`else
  task automatic test_stall;
    int cnt, wcnt;
    cnt = 0; wcnt = 0;
    b3.stall = 1'b1;
    b3.start = 1'b1; tick(); b3.start = 1'b0;
    while (b3.busy === 1'b1 && cnt < 100) begin cnt++; wcnt += int'(b3.we); tick(); end
    b3.stall = 1'b0;
    n_cmp++;
    if (cnt != 16) begin n_bad++; $display("FAIL stall_ignored_busy got %0d want 16", cnt); end
    n_cmp++;
    if (wcnt != 12) begin n_bad++; $display("FAIL stall_ignored_we got %0d want 12", wcnt); end
  endtask
`endif

  real ram_re [2][512];
  real ram_im [2][512];

  task automatic test_impulse;
    real pi, ar, ai, br, bi, wr, wi, tr, ti;
    int cyc, busy_cnt, bad;
    logic rs_d, done_seen;
    logic [7:0] tw_d;
    pi = 3.14159265358979;
    for (int k = 0; k < 512; k++) begin
      ram_re[0][k] = 0.0; ram_im[0][k] = 0.0;
      ram_re[1][k] = 0.0; ram_im[1][k] = 0.0;
    end
    ram_re[0][0] = 1000.0;
    rs_d = 1'b0; tw_d = '0; cyc = 0; busy_cnt = 0; done_seen = 1'b0;
    b9.start = 1'b1; tick(); b9.start = 1'b0;
    while (!done_seen && cyc < 5000) begin
      busy_cnt += int'(b9.busy);
      if (b9.we === 1'b1) begin
        ar = ram_re[rs_d][b9.wr_adr_a]; ai = ram_im[rs_d][b9.wr_adr_a];
        br = ram_re[rs_d][b9.wr_adr_b]; bi = ram_im[rs_d][b9.wr_adr_b];
        wr = $cos(2.0 * pi * real'(tw_d) / 512.0);
        wi = -$sin(2.0 * pi * real'(tw_d) / 512.0);
        tr = br * wr - bi * wi;
        ti = br * wi + bi * wr;
        ram_re[!rs_d][b9.wr_adr_a] = ar + tr; ram_im[!rs_d][b9.wr_adr_a] = ai + ti;
        ram_re[!rs_d][b9.wr_adr_b] = ar - tr; ram_im[!rs_d][b9.wr_adr_b] = ai - ti;
      end
      rs_d = b9.rd_sel;
      tw_d = b9.tw_adr;
      done_seen = (b9.done === 1'b1);
      cyc++;
      tick();
    end
    n_cmp++;
    if (!done_seen) begin n_bad++; $display("FAIL impulse_timeout got no done within %0d cycles want done", cyc); end
    n_cmp++;
    if (busy_cnt != 2314) begin n_bad++; $display("FAIL impulse_busy_cycles got %0d want 2314", busy_cnt); end
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (ram_re[1][k] > 1001.0 || ram_re[1][k] < 999.0 || ram_im[1][k] > 1.0 || ram_im[1][k] < -1.0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL impulse_bins got %0d bins off (bin0 re=%f) want 0 off, all 1000", bad, ram_re[1][0]);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    tick();
    test_start_ignored();
    test_start_held();
    tick();
    test_reset_mid();
    tick();
    test_stall();
    tick();
    test_impulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
